// File: rtl/obj_tri_pkg.sv
`default_nettype none
// ============================================================================
// Module  : obj_tri_pkg
// Brief   : Shared types and default constants for the object-to-triangle
//           generator (FSM state, vertex record, per-type depth and colour).
// Revision: 1.0 - initial release
// ============================================================================
package obj_tri_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam int c_def_x_w = 11;
    localparam int c_def_y_w = 10;
    localparam int c_def_z_w = 8;

    // Vertex record at the default coordinate widths.
    typedef struct packed {
        logic [c_def_x_w-1:0] x;
        logic [c_def_y_w-1:0] y;
        logic [c_def_z_w-1:0] z;
    } vertex_t;

    localparam int          c_z_player = 64;
    localparam int          c_z_bullet = 32;
    localparam logic [15:0] c_p_color  = 16'hF800;
    localparam logic [15:0] c_b_color  = 16'hFFE0;

endpackage
`default_nettype wire

// File: rtl/quad_corners.sv
`default_nettype none
// ============================================================================
// Module  : quad_corners
// Brief   : Combinational A/B/C/D corners of an axis-aligned quad around
//           (x, y) with half-size h. CLAMP_EN clamps to the screen, otherwise
//           coordinates wrap modulo 2^X_W / 2^Y_W.
// Revision: 1.0 - initial release
// ============================================================================
module quad_corners #(
    parameter int X_W      = 11,
    parameter int Y_W      = 10,
    parameter int H_W      = 8,
    parameter int SCREEN_W = 1280,
    parameter int SCREEN_H = 720
) (
    input  logic [X_W-1:0]      x,
    input  logic [Y_W-1:0]      y,
    input  logic [H_W-1:0]      h,
    output logic [3:0][X_W-1:0] corner_x,
    output logic [3:0][Y_W-1:0] corner_y
);

    logic [X_W-1:0] w_x_lo, w_x_hi;
    logic [Y_W-1:0] w_y_lo, w_y_hi;

`ifdef CLAMP_EN
    // Two guard bits keep x+h from overflowing into the sign bit near the top.
    localparam int c_sx_w = X_W + 2;
    localparam int c_sy_w = Y_W + 2;
    localparam logic signed [c_sx_w-1:0] c_x_max = c_sx_w'(SCREEN_W - 1);
    localparam logic signed [c_sy_w-1:0] c_y_max = c_sy_w'(SCREEN_H - 1);

    logic signed [c_sx_w-1:0] w_sx_lo, w_sx_hi;
    logic signed [c_sy_w-1:0] w_sy_lo, w_sy_hi;

    function automatic logic [X_W-1:0] fit_x(input logic signed [c_sx_w-1:0] v);
        if (v[c_sx_w-1])     fit_x = '0;
        else if (v > c_x_max) fit_x = c_x_max[X_W-1:0];
        else                  fit_x = v[X_W-1:0];
    endfunction

    function automatic logic [Y_W-1:0] fit_y(input logic signed [c_sy_w-1:0] v);
        if (v[c_sy_w-1])     fit_y = '0;
        else if (v > c_y_max) fit_y = c_y_max[Y_W-1:0];
        else                  fit_y = v[Y_W-1:0];
    endfunction

    assign w_sx_lo = $signed({2'b00, x}) - $signed(c_sx_w'(h));
    assign w_sx_hi = $signed({2'b00, x}) + $signed(c_sx_w'(h));
    assign w_sy_lo = $signed({2'b00, y}) - $signed(c_sy_w'(h));
    assign w_sy_hi = $signed({2'b00, y}) + $signed(c_sy_w'(h));

    assign w_x_lo = fit_x(w_sx_lo);
    assign w_x_hi = fit_x(w_sx_hi);
    assign w_y_lo = fit_y(w_sy_lo);
    assign w_y_hi = fit_y(w_sy_hi);
`else
    assign w_x_lo = x - X_W'(h);
    assign w_x_hi = x + X_W'(h);
    assign w_y_lo = y - Y_W'(h);
    assign w_y_hi = y + Y_W'(h);
`endif

    // Corner order A, B, C, D.
    assign corner_x = {w_x_lo, w_x_hi, w_x_hi, w_x_lo};
    assign corner_y = {w_y_hi, w_y_hi, w_y_lo, w_y_lo};

endmodule
`default_nettype wire

// File: rtl/obj_tri_gen.sv
`default_nettype none
// ============================================================================
// Module  : obj_tri_gen
// Brief   : Streams two triangles per enabled object of a frame snapshot.
//           Optional macro CLAMP_EN clamps corners to the screen bounds.
// Revision: 1.0 - initial release
// ============================================================================
module obj_tri_gen
    import obj_tri_pkg::*;
#(
    parameter int                 NUM_OBJ     = 4,
    parameter int                 NUM_PLAYERS = 2,
    parameter int                 X_W         = 11,
    parameter int                 Y_W         = 10,
    parameter int                 Z_W         = 8,
    parameter int                 COLOR_W     = 16,
    parameter int                 P_HALF      = 4,
    parameter int                 B_HALF      = 1,
    parameter int                 Z_PLAYER    = c_z_player,
    parameter int                 Z_BULLET    = c_z_bullet,
    parameter logic [COLOR_W-1:0] P_COLOR     = c_p_color,
    parameter logic [COLOR_W-1:0] B_COLOR     = c_b_color,
    parameter int                 SCREEN_W    = 1280,
    parameter int                 SCREEN_H    = 720
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              valid_in,
    output logic                              ready_in,
    input  logic [NUM_OBJ-1:0][X_W+Y_W-1:0]   obj_location,
    input  logic [NUM_OBJ-1:0]                obj_enable,
    output logic                              valid_out,
    input  logic                              ready_out,
    output logic [2:0][X_W-1:0]               triangle_x,
    output logic [2:0][Y_W-1:0]               triangle_y,
    output logic [2:0][Z_W-1:0]               triangle_z,
    output logic [COLOR_W-1:0]                color,
    output logic                              last_out,
    output logic                              busy_out
);

    localparam int                 c_idx_w       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
    localparam int                 c_h_w         = 8;
    localparam logic [c_idx_w:0]   c_num_players = (c_idx_w + 1)'(NUM_PLAYERS);

    state_t                           r_state;
    logic [NUM_OBJ-1:0][X_W+Y_W-1:0]  r_loc;
    logic [NUM_OBJ-1:0]               r_en;
    logic [c_idx_w-1:0]               r_idx;
    logic                             r_tri;
    logic                             r_done;
    logic                             r_valid;
    logic                             r_last;
    logic [2:0][X_W-1:0]              r_tx;
    logic [2:0][Y_W-1:0]              r_ty;
    logic [2:0][Z_W-1:0]              r_tz;
    logic [COLOR_W-1:0]               r_color;

    logic                             w_is_player;
    logic                             w_slot_en;
    logic                             w_no_higher;
    logic                             w_advance;
    logic [X_W-1:0]                   w_x;
    logic [Y_W-1:0]                   w_y;
    logic [c_h_w-1:0]                 w_h;
    logic [Z_W-1:0]                   w_z;
    logic [3:0][X_W-1:0]              w_cx;
    logic [3:0][Y_W-1:0]              w_cy;
    logic [2:0][X_W-1:0]              w_tx;
    logic [2:0][Y_W-1:0]              w_ty;

    assign w_x         = r_loc[r_idx][X_W+Y_W-1:Y_W];
    assign w_y         = r_loc[r_idx][Y_W-1:0];
    assign w_is_player = {1'b0, r_idx} < c_num_players;
    assign w_h         = w_is_player ? c_h_w'(P_HALF) : c_h_w'(B_HALF);
    assign w_z         = w_is_player ? Z_W'(Z_PLAYER) : Z_W'(Z_BULLET);
    assign w_slot_en   = r_en[r_idx];
    assign w_advance   = !r_valid || ready_out;

    // Final triangle of the frame: no enabled slot above the current one.
    always_comb begin
        w_no_higher = 1'b1;
        for (int i = 0; i < NUM_OBJ; i++) begin
            if (i > int'(r_idx) && r_en[i]) begin
                w_no_higher = 1'b0;
            end
        end
    end

    quad_corners #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .H_W      (c_h_w),
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_quad_corners (
        .x        (w_x),
        .y        (w_y),
        .h        (w_h),
        .corner_x (w_cx),
        .corner_y (w_cy)
    );

    // tri0 = A,B,C ; tri1 = A,C,D
    always_comb begin
        w_tx[0] = w_cx[0];
        w_ty[0] = w_cy[0];
        w_tx[1] = r_tri ? w_cx[2] : w_cx[1];
        w_ty[1] = r_tri ? w_cy[2] : w_cy[1];
        w_tx[2] = r_tri ? w_cx[3] : w_cx[2];
        w_ty[2] = r_tri ? w_cy[3] : w_cy[2];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
            r_loc   <= '0;
            r_en    <= '0;
            r_idx   <= '0;
            r_tri   <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_tx    <= '0;
            r_ty    <= '0;
            r_tz    <= '0;
            r_color <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_loc  <= obj_location;
                        r_en   <= obj_enable;
                        r_idx  <= '0;
                        r_tri  <= 1'b0;
                        r_done <= 1'b0;
                        if (|obj_enable) begin
                            r_state <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (r_valid && ready_out && r_last) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_state <= IDLE;
                    end else if (w_advance && !r_done) begin
                        if (!w_slot_en) begin
                            r_valid <= 1'b0;
                            r_idx   <= r_idx + 1'b1;
                        end else begin
                            r_valid <= 1'b1;
                            r_tx    <= w_tx;
                            r_ty    <= w_ty;
                            r_tz    <= {3{w_z}};
                            r_color <= w_is_player ? P_COLOR : B_COLOR;
                            r_last  <= r_tri && w_no_higher;
                            if (r_tri) begin
                                r_tri  <= 1'b0;
                                r_idx  <= r_idx + 1'b1;
                                r_done <= w_no_higher;
                            end else begin
                                r_tri <= 1'b1;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ready_in   = (r_state == IDLE) && rst_n_in;
    assign busy_out   = (r_state == EMIT);
    assign valid_out  = r_valid;
    assign last_out   = r_last;
    assign triangle_x = r_tx;
    assign triangle_y = r_ty;
    assign triangle_z = r_tz;
    assign color      = r_color;

endmodule
`default_nettype wire

// File: tb/tb_obj_tri_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_obj_tri_gen
// Brief   : Self-checking bench for obj_tri_gen (P_HALF=2, B_HALF=1);
//           expected triangles come from a scoreboard queue.
// Revision: 1.0 - initial release
// ============================================================================
module tb_obj_tri_gen;
    import obj_tri_pkg::*;

    logic                  clk_in = 1'b0;
    logic                  rst_n_in;
    logic                  valid_in;
    logic                  ready_in;
    logic [3:0][20:0]      obj_location;
    logic [3:0]            obj_enable;
    logic                  valid_out;
    logic                  ready_out;
    logic [2:0][10:0]      triangle_x;
    logic [2:0][9:0]       triangle_y;
    logic [2:0][7:0]       triangle_z;
    logic [15:0]           color;
    logic                  last_out;
    logic                  busy_out;

    obj_tri_gen #(
        .P_HALF (2),
        .B_HALF (1)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .obj_location (obj_location),
        .obj_enable   (obj_enable),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .triangle_x   (triangle_x),
        .triangle_y   (triangle_y),
        .triangle_z   (triangle_z),
        .color        (color),
        .last_out     (last_out),
        .busy_out     (busy_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        vertex_t [2:0] v;
        logic [15:0]   color;
        logic          last;
    } exp_t;

    typedef struct {
        logic [3:0][20:0] loc;
        logic [3:0]       en;
        int               stall_at;
        int               stall_len;
        bit               poke;
        int               ntri;
        int               last_cyc;
    } frame_t;

    exp_t   q[$];
    frame_t tbl[7];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [20:0] pk(input int x, input int y);
        pk = {11'(x), 10'(y)};
    endfunction

    function automatic int fit_x(input int v);
`ifdef CLAMP_EN
        fit_x = (v < 0) ? 0 : ((v > 1279) ? 1279 : v);
`else
        fit_x = v & 2047;
`endif
    endfunction

    function automatic int fit_y(input int v);
`ifdef CLAMP_EN
        fit_y = (v < 0) ? 0 : ((v > 719) ? 719 : v);
`else
        fit_y = v & 1023;
`endif
    endfunction

    task automatic push_model(input frame_t f);
        int   hi, x, y, h;
        int   cx[4];
        int   cy[4];
        int   k[3];
        exp_t e;
        hi = -1;
        for (int s = 0; s < 4; s++) if (f.en[s]) hi = s;
        for (int s = 0; s < 4; s++) begin
            if (f.en[s]) begin
                x = int'(f.loc[s][20:10]);
                y = int'(f.loc[s][9:0]);
                h = (s < 2) ? 2 : 1;
                cx[0] = fit_x(x - h); cx[1] = fit_x(x + h); cx[2] = cx[1]; cx[3] = cx[0];
                cy[0] = fit_y(y - h); cy[1] = cy[0]; cy[2] = fit_y(y + h); cy[3] = cy[2];
                for (int t = 0; t < 2; t++) begin
                    k[0] = 0;
                    k[1] = (t == 1) ? 2 : 1;
                    k[2] = (t == 1) ? 3 : 2;
                    for (int i = 0; i < 3; i++) begin
                        e.v[i].x = 11'(cx[k[i]]);
                        e.v[i].y = 10'(cy[k[i]]);
                        e.v[i].z = (s < 2) ? 8'd64 : 8'd32;
                    end
                    e.color = (s < 2) ? 16'hF800 : 16'hFFE0;
                    e.last  = (t == 1) && (s == hi);
                    q.push_back(e);
                end
            end
        end
    endtask

    // Entered and left on a negedge.
    task automatic run_frame(input frame_t f, input int id);
        int   cyc, acc, stall_left, last_cyc;
        bit   done;
        exp_t act;
        check($sformatf("f%0d_ready_in_idle", id), 32'(ready_in), 1);
        valid_in     = 1'b1;
        obj_location = f.loc;
        obj_enable   = f.en;
        push_model(f);
        @(negedge clk_in);
        valid_in = 1'b0;
        if (f.en == 4'b0000) begin
            check($sformatf("f%0d_zero_busy", id), 32'(busy_out), 0);
            check($sformatf("f%0d_zero_ready", id), 32'(ready_in), 1);
            repeat (2) begin
                @(negedge clk_in);
                check($sformatf("f%0d_zero_valid", id), 32'(valid_out), 0);
            end
            return;
        end
        check($sformatf("f%0d_emit_flags", id), {30'd0, busy_out, ready_in}, 2);
        if (f.poke) begin
            valid_in     = 1'b1;
            obj_location = ~f.loc;
            obj_enable   = 4'hF;
        end
        cyc = 0; acc = 0; done = 1'b0; last_cyc = -1;
        stall_left = f.stall_len;
        while (!done && cyc < 60) begin
            @(negedge clk_in);
            cyc++;
            valid_in  = 1'b0;
            ready_out = 1'b1;
            if (valid_out) begin
                if (acc == f.stall_at && stall_left > 0) begin
                    ready_out = 1'b0;
                    stall_left--;
                end
                for (int i = 0; i < 3; i++) begin
                    act.v[i].x = triangle_x[i];
                    act.v[i].y = triangle_y[i];
                    act.v[i].z = triangle_z[i];
                end
                act.color = color;
                act.last  = last_out;
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL f%0d_extra_tri: got %h expected none", id, act);
                end else if (act !== q[0]) begin
                    $display("FAIL f%0d_tri%0d: got %h expected %h", id, acc, act, q[0]);
                end else begin
                    n_pass++;
                end
                if (ready_out) begin
                    if (q.size() > 0) void'(q.pop_front());
                    acc++;
                    if (last_out) begin
                        done     = 1'b1;
                        last_cyc = cyc;
                    end
                end
            end
        end
        check($sformatf("f%0d_timeout", id), 32'(done), 1);
        check($sformatf("f%0d_count", id), acc, f.ntri);
        check($sformatf("f%0d_latency", id), last_cyc, f.last_cyc);
        check($sformatf("f%0d_queue_left", id), q.size(), 0);
        q.delete();
        @(negedge clk_in);
        check($sformatf("f%0d_post_idle", id), {29'd0, busy_out, ready_in, valid_out}, 2);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n_in     = 1'b0;
        valid_in     = 1'b0;
        ready_out    = 1'b1;
        obj_location = '0;
        obj_enable   = '0;

        tbl[0] = '{loc: {pk(14,6), pk(7,4), pk(10,6), pk(5,4)}, en: 4'b1111,
                   stall_at: -1, stall_len: 0, poke: 1'b1, ntri: 8, last_cyc: 8};
        tbl[1] = '{loc: {pk(14,6), pk(7,4), pk(10,6), pk(5,4)}, en: 4'b0101,
                   stall_at: -1, stall_len: 0, poke: 1'b0, ntri: 4, last_cyc: 5};
        tbl[2] = '{loc: {pk(14,6), pk(7,4), pk(10,6), pk(5,4)}, en: 4'b0000,
                   stall_at: -1, stall_len: 0, poke: 1'b0, ntri: 0, last_cyc: 0};
        tbl[3] = '{loc: {pk(14,6), pk(7,4), pk(10,6), pk(5,4)}, en: 4'b1111,
                   stall_at: 2, stall_len: 3, poke: 1'b0, ntri: 8, last_cyc: 11};
        tbl[4] = '{loc: {pk(0,0), pk(9,9), pk(300,200), pk(1,1)}, en: 4'b1001,
                   stall_at: -1, stall_len: 0, poke: 1'b0, ntri: 4, last_cyc: 6};
        tbl[5] = '{loc: {pk(1279,719), pk(3,3), pk(50,60), pk(20,30)}, en: 4'b1000,
                   stall_at: -1, stall_len: 0, poke: 1'b0, ntri: 2, last_cyc: 5};
        tbl[6] = '{loc: {pk(5,5), pk(100,719), pk(2046,1022), pk(8,8)}, en: 4'b0110,
                   stall_at: 1, stall_len: 2, poke: 1'b0, ntri: 4, last_cyc: 7};

        #3;
        check("reset_outputs", {26'd0, valid_out, busy_out, last_out, ready_in,
                                |triangle_x, |color}, 0);
        repeat (2) @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        check("reset_release", {29'd0, ready_in, busy_out, valid_out}, 4);
        @(negedge clk_in);

        for (int i = 0; i < 7; i++) run_frame(tbl[i], i);

        // Asynchronous reset in the middle of a frame.
        valid_in     = 1'b1;
        obj_location = tbl[0].loc;
        obj_enable   = tbl[0].en;
        @(negedge clk_in);
        valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check("midrst_pre_valid", 32'(valid_out), 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        check("midrst_outputs", {27'd0, valid_out, busy_out, last_out, |triangle_x, |color}, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        check("midrst_release", {30'd0, ready_in, busy_out}, 2);
        @(negedge clk_in);
        run_frame(tbl[4], 7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
